// File: rtl/mvm_rx_arbiter.sv
// mvm_rx_arbiter: packet-level round-robin arbiter sharing one AXI-Stream rx port
// among NREQ requesters, with the grant locked from first beat to tlast.
module mvm_rx_arbiter #(
   parameter int NREQ  = 4,
   parameter int DATAW = 512,
   parameter int BYTEW = 8,
   parameter int IDW   = 32,
   parameter int DESTW = 12,
   parameter int USERW = 75
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        s_tvalid,
   input  logic [NREQ*DATAW-1:0]  s_tdata,
   input  logic [NREQ*BYTEW-1:0]  s_tstrb,
   input  logic [NREQ*BYTEW-1:0]  s_tkeep,
   input  logic [NREQ*IDW-1:0]    s_tid,
   input  logic [NREQ*DESTW-1:0]  s_tdest,
   input  logic [NREQ*USERW-1:0]  s_tuser,
   input  logic [NREQ-1:0]        s_tlast,
   output logic [NREQ-1:0]        s_tready,
   output logic                   m_tvalid,
   output logic [DATAW-1:0]       m_tdata,
   output logic [BYTEW-1:0]       m_tstrb,
   output logic [BYTEW-1:0]       m_tkeep,
   output logic [IDW-1:0]         m_tid,
   output logic [DESTW-1:0]       m_tdest,
   output logic [USERW-1:0]       m_tuser,
   output logic                   m_tlast,
   input  logic                   m_tready,
   output logic [NREQ-1:0]        grant,
   output logic                   busy
);
   localparam int PW = $clog2(NREQ);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d, gidx, pick;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic              found, hs, last_hs;
   logic              m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
   logic [DATAW-1:0]  m_tdata_q, m_tdata_d;
   logic [BYTEW-1:0]  m_tstrb_q, m_tstrb_d, m_tkeep_q, m_tkeep_d;
   logic [IDW-1:0]    m_tid_q, m_tid_d;
   logic [DESTW-1:0]  m_tdest_q, m_tdest_d;
   logic [USERW-1:0]  m_tuser_q, m_tuser_d;

   function automatic int wrap(input int v);
      return (v >= NREQ) ? v - NREQ : v;
   endfunction

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NREQ; i++) if (grant_q[i]) gidx = PW'(i);
      pick  = '0;
      found = 1'b0;
      // first valid requester at or after rr_ptr, wrapping at NREQ
      for (int k = 0; k < NREQ; k++) begin
         if (!found && s_tvalid[wrap(int'(rr_ptr_q) + k)]) begin
            found = 1'b1;
            pick  = PW'(wrap(int'(rr_ptr_q) + k));
         end
      end
      s_tready   = grant_q & {NREQ{~m_tvalid_q | m_tready}};
      hs         = |(s_tvalid & s_tready);
      last_hs    = hs & s_tlast[gidx];
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      if (state_q == IDLE) begin
         if (found) begin
            state_d = LOCK;
            grant_d = NREQ'(1) << pick;
         end
      end else if (last_hs) begin
         state_d  = IDLE;
         grant_d  = '0;
         rr_ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
      m_tvalid_d = hs | (m_tvalid_q & ~m_tready);
      m_tdata_d  = hs ? s_tdata[gidx*DATAW +: DATAW] : m_tdata_q;
      m_tstrb_d  = hs ? s_tstrb[gidx*BYTEW +: BYTEW] : m_tstrb_q;
      m_tkeep_d  = hs ? s_tkeep[gidx*BYTEW +: BYTEW] : m_tkeep_q;
      m_tid_d    = hs ? s_tid[gidx*IDW +: IDW] : m_tid_q;
      m_tdest_d  = hs ? s_tdest[gidx*DESTW +: DESTW] : m_tdest_q;
      m_tuser_d  = hs ? s_tuser[gidx*USERW +: USERW] : m_tuser_q;
      m_tlast_d  = hs ? s_tlast[gidx] : m_tlast_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tstrb_q  <= '0;
         m_tkeep_q  <= '0;
         m_tid_q    <= '0;
         m_tdest_q  <= '0;
         m_tuser_q  <= '0;
         m_tlast_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
         m_tstrb_q  <= m_tstrb_d;
         m_tkeep_q  <= m_tkeep_d;
         m_tid_q    <= m_tid_d;
         m_tdest_q  <= m_tdest_d;
         m_tuser_q  <= m_tuser_d;
         m_tlast_q  <= m_tlast_d;
      end
   end

   assign m_tvalid = m_tvalid_q;
   assign m_tdata  = m_tdata_q;
   assign m_tstrb  = m_tstrb_q;
   assign m_tkeep  = m_tkeep_q;
   assign m_tid    = m_tid_q;
   assign m_tdest  = m_tdest_q;
   assign m_tuser  = m_tuser_q;
   assign m_tlast  = m_tlast_q;
   assign grant    = grant_q;
   assign busy     = (state_q == LOCK);
endmodule

// File: tb/tb_mvm_rx_arbiter.sv
// tb_mvm_rx_arbiter: directed-step bench for the packet round-robin arbiter,
// checking grant order, packet locking, backpressure and async reset.
module tb_mvm_rx_arbiter;
   localparam int NREQ = 4, DATAW = 512, BYTEW = 8, IDW = 32, DESTW = 12, USERW = 75;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       s_tvalid, s_tlast, s_tready;
   logic [NREQ*DATAW-1:0] s_tdata;
   logic [NREQ*BYTEW-1:0] s_tstrb, s_tkeep;
   logic [NREQ*IDW-1:0]   s_tid;
   logic [NREQ*DESTW-1:0] s_tdest;
   logic [NREQ*USERW-1:0] s_tuser;
   logic                  m_tvalid, m_tlast, m_tready, busy;
   logic [DATAW-1:0]      m_tdata;
   logic [BYTEW-1:0]      m_tstrb, m_tkeep;
   logic [IDW-1:0]        m_tid;
   logic [DESTW-1:0]      m_tdest;
   logic [USERW-1:0]      m_tuser;
   logic [NREQ-1:0]       grant;
   int                    vectors = 0;
   int                    miscompares = 0;

   mvm_rx_arbiter #(.NREQ(NREQ), .DATAW(DATAW), .BYTEW(BYTEW), .IDW(IDW),
                    .DESTW(DESTW), .USERW(USERW)) dut (
      .clk(clk), .rst(rst),
      .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tkeep(s_tkeep),
      .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser), .s_tlast(s_tlast),
      .s_tready(s_tready),
      .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep),
      .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser), .m_tlast(m_tlast),
      .m_tready(m_tready), .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Beat payload is derived from the tuser tag so tdata/tid can be checked too.
   task automatic drv(input int i, input logic v, input logic [15:0] u, input logic l);
      s_tvalid[i]               = v;
      s_tuser[i*USERW +: USERW] = USERW'(u);
      s_tdata[i*DATAW +: DATAW] = DATAW'({16'hDA7A, u});
      s_tid[i*IDW +: IDW]       = IDW'(i + 1);
      s_tkeep[i*BYTEW +: BYTEW] = '1;
      s_tstrb[i*BYTEW +: BYTEW] = '1;
      s_tlast[i]                = l;
   endtask

   initial begin
      rst = 1'b0;
      m_tready = 1'b1;
      s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tstrb = '0; s_tkeep = '0;
      s_tid = '0; s_tdest = '0; s_tuser = '0;
      step(); step();
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_mvalid", 64'(m_tvalid), 64'(0));
      chk("rst_sready", 64'(s_tready), 64'(0));
      chk("rst_mdata", m_tdata[63:0], 64'(0));
      chk("rst_muser", 64'(m_tuser), 64'(0));
      rst = 1'b1;
      step();

      // 1: req0 and req2 one-beat packets
      drv(0, 1'b1, 16'h100, 1'b1);
      drv(2, 1'b1, 16'h120, 1'b1);
      chk("t1_idle_sready", 64'(s_tready), 64'(0));
      step();
      chk("t1_grant0", 64'(grant), 64'(4'b0001));
      chk("t1_busy", 64'(busy), 64'(1));
      chk("t1_sready0", 64'(s_tready), 64'(4'b0001));
      step();
      drv(0, 1'b0, 16'h100, 1'b1);
      chk("t1_mvalid0", 64'(m_tvalid), 64'(1));
      chk("t1_muser0", 64'(m_tuser), 64'(16'h100));
      chk("t1_mdata0", 64'(m_tdata[31:0]), 64'(32'hDA7A_0100));
      chk("t1_mid0", 64'(m_tid), 64'(1));
      chk("t1_grant_idle", 64'(grant), 64'(0));
      step();
      chk("t1_gap", 64'(m_tvalid), 64'(0));
      chk("t1_grant2", 64'(grant), 64'(4'b0100));
      step();
      drv(2, 1'b0, 16'h120, 1'b1);
      chk("t1_muser2", 64'(m_tuser), 64'(16'h120));
      chk("t1_mlast2", 64'(m_tlast), 64'(1));
      step();
      chk("t1_drain", 64'(m_tvalid), 64'(0));

      // 2: req1 three-beat packet locks out req0
      drv(1, 1'b1, 16'h111, 1'b0);
      step();
      chk("t2_grant1", 64'(grant), 64'(4'b0010));
      drv(0, 1'b1, 16'h101, 1'b1);
      chk("t2_sready_b1", 64'(s_tready), 64'(4'b0010));
      step();
      drv(1, 1'b1, 16'h112, 1'b0);
      chk("t2_muser_b1", 64'(m_tuser), 64'(16'h111));
      chk("t2_sready_b2", 64'(s_tready), 64'(4'b0010));
      step();
      drv(1, 1'b1, 16'h113, 1'b1);
      chk("t2_muser_b2", 64'(m_tuser), 64'(16'h112));
      chk("t2_mlast_b2", 64'(m_tlast), 64'(0));
      chk("t2_sready_b3", 64'(s_tready), 64'(4'b0010));
      step();
      drv(1, 1'b0, 16'h113, 1'b1);
      chk("t2_muser_b3", 64'(m_tuser), 64'(16'h113));
      chk("t2_mvalid_b3", 64'(m_tvalid), 64'(1));
      step();
      chk("t2_grant0", 64'(grant), 64'(4'b0001));
      chk("t2_gap", 64'(m_tvalid), 64'(0));
      step();
      drv(0, 1'b0, 16'h101, 1'b1);
      chk("t2_muser0", 64'(m_tuser), 64'(16'h101));
      step();

      // 3: backpressure mid-packet on req3
      drv(3, 1'b1, 16'h131, 1'b0);
      step();
      chk("t3_grant3", 64'(grant), 64'(4'b1000));
      step();
      drv(3, 1'b1, 16'h132, 1'b0);
      m_tready = 1'b0;
      #1;
      chk("t3_stall_sready", 64'(s_tready), 64'(0));
      for (int n = 0; n < 5; n++) begin
         step();
         chk("t3_hold_valid", 64'(m_tvalid), 64'(1));
         chk("t3_hold_data", 64'(m_tdata[31:0]), 64'(32'hDA7A_0131));
         chk("t3_hold_sready", 64'(s_tready), 64'(0));
      end
      m_tready = 1'b1;
      #1;
      chk("t3_release_sready", 64'(s_tready), 64'(4'b1000));
      step();
      drv(3, 1'b1, 16'h133, 1'b0);
      chk("t3_muser_b2", 64'(m_tuser), 64'(16'h132));
      step();
      drv(3, 1'b1, 16'h134, 1'b1);
      chk("t3_muser_b3", 64'(m_tuser), 64'(16'h133));
      step();
      drv(3, 1'b0, 16'h134, 1'b1);
      chk("t3_muser_b4", 64'(m_tuser), 64'(16'h134));
      chk("t3_grant_idle", 64'(grant), 64'(0));
      step();
      chk("t3_drain", 64'(m_tvalid), 64'(0));

      // 4: all requesters continuously valid, round-robin order
      for (int i = 0; i < NREQ; i++) drv(i, 1'b1, 16'(16'h140 + i), 1'b1);
      for (int p = 0; p < 8; p++) begin
         step();
         chk("t4_grant", 64'(grant), 64'(1) << (p % 4));
         step();
         chk("t4_muser", 64'(m_tuser), 64'(16'h140 + (p % 4)));
      end
      s_tvalid = '0;
      step();

      // 5: move rr_ptr to 2, then reset during beat 2 of req2's packet
      drv(1, 1'b1, 16'h151, 1'b1);
      step();
      chk("t5_grant1", 64'(grant), 64'(4'b0010));
      step();
      drv(1, 1'b0, 16'h151, 1'b1);
      drv(2, 1'b1, 16'h161, 1'b0);
      step();
      chk("t5_grant2", 64'(grant), 64'(4'b0100));
      step();
      drv(2, 1'b1, 16'h162, 1'b0);
      chk("t5_muser_b1", 64'(m_tuser), 64'(16'h161));
      step();
      chk("t5_muser_b2", 64'(m_tuser), 64'(16'h162));
      rst = 1'b0;
      drv(0, 1'b1, 16'h171, 1'b1);
      #1;
      chk("t5_rst_mvalid", 64'(m_tvalid), 64'(0));
      chk("t5_rst_grant", 64'(grant), 64'(0));
      chk("t5_rst_busy", 64'(busy), 64'(0));
      chk("t5_rst_muser", 64'(m_tuser), 64'(0));
      step();
      chk("t5_rst_hold", 64'(grant), 64'(0));
      rst = 1'b1;
      step();
      chk("t5_rr_reset", 64'(grant), 64'(4'b0001));
      step();
      s_tvalid = '0;
      chk("t5_muser0", 64'(m_tuser), 64'(16'h171));
      step();
      chk("t5_drain", 64'(m_tvalid), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
